// File: rtl/mf_coeff_loader.sv
// Captures a streamed complex coefficient set into a register bank in matched-filter
// order (time-reversed, conjugated) and serves it through a 1-cycle registered read port.
module mf_coeff_loader #(
   parameter int LENGTH     = 800,
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] inRe,
   input  logic [DATA_WIDTH-1:0] inIm,
   input  logic                  inValid,
   input  logic                  inFinishedFlag,
   input  logic [ADDR_WIDTH-1:0] rdAddr,
   output logic [DATA_WIDTH-1:0] rdRe,
   output logic [DATA_WIDTH-1:0] rdIm,
   output logic                  loadEnable,
   output logic                  coeffReady,
   output logic                  shortFlag,
   output logic                  overflowFlag,
   output logic [1:0]            dbgState
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
   localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      ZERO_FILL = 2'd2,
      READY     = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  enable_dly_q, enable_dly_d;
   logic                  short_q, short_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] rd_re_q, rd_re_d;
   logic [DATA_WIDTH-1:0] rd_im_q, rd_im_d;

   logic [DATA_WIDTH-1:0] bank_re [LENGTH];
   logic [DATA_WIDTH-1:0] bank_im [LENGTH];

   logic                  enable_rise;
   logic                  wr_en;
   logic [IW-1:0]         wr_idx;
   logic [DATA_WIDTH-1:0] wr_re;
   logic [DATA_WIDTH-1:0] wr_im;
   logic [DATA_WIDTH-1:0] neg_im;
   logic                  rd_in_range;
   logic [IW-1:0]         rd_idx;

   // Conjugation saturates the one value whose negation is unrepresentable.
   assign neg_im      = (inIm == MIN_VAL) ? MAX_VAL : (~inIm + {{(DATA_WIDTH-1){1'b0}}, 1'b1});
   assign enable_rise = enable & ~enable_dly_q;
   assign rd_in_range = ({1'b0, rdAddr} < LEN_C);
   assign rd_idx      = IW'(rdAddr);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      short_d      = short_q;
      overflow_d   = overflow_q;
      enable_dly_d = enable;
      wr_en        = 1'b0;
      wr_re        = '0;
      wr_im        = '0;
      // Entry `count` lands at the mirrored address, giving the time reversal.
      wr_idx       = IW'(LEN_C - CW'(1) - count_q);

      case (state_q)
         IDLE: begin
            if (enable_rise) begin
               state_d    = LOAD;
               count_d    = '0;
               short_d    = 1'b0;
               overflow_d = 1'b0;
            end
         end
         LOAD: begin
            if (inValid && (count_q < LEN_C)) begin
               wr_en   = 1'b1;
               wr_re   = inRe;
               wr_im   = neg_im;
               count_d = count_q + CW'(1);
            end
            if (count_d == LEN_C) begin
               state_d = READY;
            end else if (inFinishedFlag) begin
               state_d = ZERO_FILL;
               short_d = 1'b1;
            end
         end
         ZERO_FILL: begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
            if (count_d == LEN_C) begin
               state_d = READY;
            end
         end
         READY: begin
            if (enable_rise) begin
               state_d    = LOAD;
               count_d    = '0;
               short_d    = 1'b0;
               overflow_d = 1'b0;
            end else if (inValid) begin
               overflow_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_re_d = '0;
      rd_im_d = '0;
      if (rd_in_range) begin
         rd_re_d = bank_re[rd_idx];
         rd_im_d = bank_im[rd_idx];
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         count_q      <= '0;
         enable_dly_q <= 1'b0;
         short_q      <= 1'b0;
         overflow_q   <= 1'b0;
         rd_re_q      <= '0;
         rd_im_q      <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         enable_dly_q <= enable_dly_d;
         short_q      <= short_d;
         overflow_q   <= overflow_d;
         rd_re_q      <= rd_re_d;
         rd_im_q      <= rd_im_d;
      end
   end

   // Bank has no reset; a same-edge read sees the pre-write contents.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         bank_re[wr_idx] <= wr_re;
         bank_im[wr_idx] <= wr_im;
      end
   end

   assign rdRe         = rd_re_q;
   assign rdIm         = rd_im_q;
   assign loadEnable   = (state_q == LOAD);
   assign coeffReady   = (state_q == READY);
   assign shortFlag    = short_q;
   assign overflowFlag = overflow_q;
   assign dbgState     = state_q;

endmodule

// File: tb/tb_mf_coeff_loader.sv
// Directed bench for mf_coeff_loader with LENGTH = 8: normal, overflow, gapped,
// saturating, short and reset/reload loads, each checked against hand-computed values.
module tb_mf_coeff_loader;

   localparam int LENGTH     = 8;
   localparam int DATA_WIDTH = 12;
   localparam int ADDR_WIDTH = 4;

   logic                  clock;
   logic                  resetN;
   logic                  enable;
   logic [DATA_WIDTH-1:0] inRe;
   logic [DATA_WIDTH-1:0] inIm;
   logic                  inValid;
   logic                  inFinishedFlag;
   logic [ADDR_WIDTH-1:0] rdAddr;
   logic [DATA_WIDTH-1:0] rdRe;
   logic [DATA_WIDTH-1:0] rdIm;
   logic                  loadEnable;
   logic                  coeffReady;
   logic                  shortFlag;
   logic                  overflowFlag;
   logic [1:0]            dbgState;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   mf_coeff_loader #(
      .LENGTH(LENGTH),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clock(clock),
      .resetN(resetN),
      .enable(enable),
      .inRe(inRe),
      .inIm(inIm),
      .inValid(inValid),
      .inFinishedFlag(inFinishedFlag),
      .rdAddr(rdAddr),
      .rdRe(rdRe),
      .rdIm(rdIm),
      .loadEnable(loadEnable),
      .coeffReady(coeffReady),
      .shortFlag(shortFlag),
      .overflowFlag(overflowFlag),
      .dbgState(dbgState)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit (%0d assertions, %0d failures)",
               assert_cnt, fail_cnt);
      $fatal(1, "timeout");
   end

   // driver tasks
   task automatic pulse_enable();
      enable = 1'b1;
      @(posedge clock); #1;
      enable = 1'b0;
   endtask

   task automatic send(input logic [DATA_WIDTH-1:0] re, input logic [DATA_WIDTH-1:0] im);
      inRe    = re;
      inIm    = im;
      inValid = 1'b1;
      @(posedge clock); #1;
      inValid = 1'b0;
   endtask

   task automatic read_addr(input logic [ADDR_WIDTH-1:0] a,
                            output logic [DATA_WIDTH-1:0] re,
                            output logic [DATA_WIDTH-1:0] im);
      rdAddr = a;
      @(posedge clock); #1;
      re = rdRe;
      im = rdIm;
   endtask

   // scenarios
   task automatic test_reset();
      resetN = 1'b0; enable = 1'b0; inRe = '0; inIm = '0;
      inValid = 1'b0; inFinishedFlag = 1'b0; rdAddr = '0;
      #1;
      assert_cnt++;
      if ({rdRe, rdIm} !== 24'h0) begin
         fail_cnt++; $display("FAIL reset_rd: got %h/%h want 0/0", rdRe, rdIm);
      end
      assert_cnt++;
      if ({loadEnable, coeffReady, shortFlag, overflowFlag} !== 4'b0000) begin
         fail_cnt++;
         $display("FAIL reset_flags: got le=%b cr=%b sf=%b of=%b want 0000",
                  loadEnable, coeffReady, shortFlag, overflowFlag);
      end
      repeat (2) @(posedge clock);
      #1 resetN = 1'b1;
      @(posedge clock); #1;
      assert_cnt++;
      if (loadEnable !== 1'b0 || coeffReady !== 1'b0) begin
         fail_cnt++; $display("FAIL idle_after_reset: le=%b cr=%b want 0 0", loadEnable, coeffReady);
      end
   endtask

   task automatic test_normal_load();
      logic [DATA_WIDTH-1:0] re, im;
      pulse_enable();
      assert_cnt++;
      if (loadEnable !== 1'b1) begin
         fail_cnt++; $display("FAIL normal_loadEnable: got %b want 1", loadEnable);
      end
      for (int k = 0; k < LENGTH; k++) begin
         if (k == LENGTH - 1) begin
            assert_cnt++;
            if (coeffReady !== 1'b0) begin
               fail_cnt++; $display("FAIL normal_early_ready: got %b want 0", coeffReady);
            end
         end
         send(DATA_WIDTH'(k + 1), DATA_WIDTH'(10 * k));
      end
      assert_cnt++;
      if (coeffReady !== 1'b1 || loadEnable !== 1'b0 || shortFlag !== 1'b0) begin
         fail_cnt++;
         $display("FAIL normal_ready: cr=%b le=%b sf=%b want 1 0 0", coeffReady, loadEnable, shortFlag);
      end
      for (int a = 0; a < LENGTH; a++) begin
         read_addr(ADDR_WIDTH'(a), re, im);
         assert_cnt++;
         if (re !== DATA_WIDTH'(8 - a) || im !== DATA_WIDTH'(-10 * (7 - a))) begin
            fail_cnt++;
            $display("FAIL normal_read[%0d]: got %0d/%0d want %0d/%0d", a,
                     $signed(re), $signed(im), 8 - a, -10 * (7 - a));
         end
      end
      read_addr(ADDR_WIDTH'(0), re, im);
      rdAddr = ADDR_WIDTH'(7);
      #1;
      assert_cnt++;
      if (rdRe !== DATA_WIDTH'(8) || rdIm !== DATA_WIDTH'(-70)) begin
         fail_cnt++;
         $display("FAIL read_latency_hold: got %0d/%0d want 8/-70", $signed(rdRe), $signed(rdIm));
      end
      @(posedge clock); #1;
      assert_cnt++;
      if (rdRe !== DATA_WIDTH'(1) || rdIm !== DATA_WIDTH'(0)) begin
         fail_cnt++;
         $display("FAIL read_latency_update: got %0d/%0d want 1/0", $signed(rdRe), $signed(rdIm));
      end
   endtask

   task automatic test_overflow();
      logic [DATA_WIDTH-1:0] re, im;
      send(DATA_WIDTH'(99), DATA_WIDTH'(99));
      assert_cnt++;
      if (overflowFlag !== 1'b1 || coeffReady !== 1'b1) begin
         fail_cnt++; $display("FAIL overflow_flag: of=%b cr=%b want 1 1", overflowFlag, coeffReady);
      end
      read_addr(ADDR_WIDTH'(8), re, im);
      assert_cnt++;
      if (re !== '0 || im !== '0) begin
         fail_cnt++; $display("FAIL oob_read: got %0d/%0d want 0/0", $signed(re), $signed(im));
      end
      read_addr(ADDR_WIDTH'(15), re, im);
      assert_cnt++;
      if (re !== '0 || im !== '0) begin
         fail_cnt++; $display("FAIL oob_read15: got %0d/%0d want 0/0", $signed(re), $signed(im));
      end
      read_addr(ADDR_WIDTH'(0), re, im);
      assert_cnt++;
      if (re !== DATA_WIDTH'(8) || im !== DATA_WIDTH'(-70)) begin
         fail_cnt++;
         $display("FAIL overflow_bank0: got %0d/%0d want 8/-70", $signed(re), $signed(im));
      end
      read_addr(ADDR_WIDTH'(3), re, im);
      assert_cnt++;
      if (re !== DATA_WIDTH'(5) || im !== DATA_WIDTH'(-40)) begin
         fail_cnt++;
         $display("FAIL overflow_bank3: got %0d/%0d want 5/-40", $signed(re), $signed(im));
      end
   endtask

   task automatic test_gapped();
      logic [DATA_WIDTH-1:0] re, im;
      pulse_enable();
      assert_cnt++;
      if (overflowFlag !== 1'b0 || coeffReady !== 1'b0 || loadEnable !== 1'b1) begin
         fail_cnt++;
         $display("FAIL gapped_restart: of=%b cr=%b le=%b want 0 0 1", overflowFlag, coeffReady, loadEnable);
      end
      for (int k = 0; k < LENGTH; k++) begin
         send(DATA_WIDTH'(k + 1), DATA_WIDTH'(10 * k));
         if (k == 3) begin
            pulse_enable();
         end else if (k < LENGTH - 1) begin
            @(posedge clock); #1;
         end
         if (k < LENGTH - 1) begin
            assert_cnt++;
            if (loadEnable !== 1'b1) begin
               fail_cnt++; $display("FAIL gapped_loadEnable[%0d]: got %b want 1", k, loadEnable);
            end
         end
      end
      assert_cnt++;
      if (coeffReady !== 1'b1) begin
         fail_cnt++; $display("FAIL gapped_ready: got %b want 1", coeffReady);
      end
      for (int a = 0; a < LENGTH; a++) begin
         read_addr(ADDR_WIDTH'(a), re, im);
         assert_cnt++;
         if (re !== DATA_WIDTH'(8 - a) || im !== DATA_WIDTH'(-10 * (7 - a))) begin
            fail_cnt++;
            $display("FAIL gapped_read[%0d]: got %0d/%0d want %0d/%0d", a,
                     $signed(re), $signed(im), 8 - a, -10 * (7 - a));
         end
      end
   endtask

   task automatic test_saturation();
      logic [DATA_WIDTH-1:0] re, im;
      pulse_enable();
      for (int k = 0; k < LENGTH; k++) begin
         if (k == 0)      send(12'h800, 12'h800);
         else if (k == 1) send(12'h7FF, 12'h7FF);
         else             send(DATA_WIDTH'(k + 1), DATA_WIDTH'(10 * k));
      end
      read_addr(ADDR_WIDTH'(7), re, im);
      assert_cnt++;
      if (re !== 12'h800 || im !== 12'h7FF) begin
         fail_cnt++;
         $display("FAIL sat_min: got %0d/%0d want -2048/2047", $signed(re), $signed(im));
      end
      read_addr(ADDR_WIDTH'(6), re, im);
      assert_cnt++;
      if (re !== 12'h7FF || im !== 12'h801) begin
         fail_cnt++;
         $display("FAIL sat_max: got %0d/%0d want 2047/-2047", $signed(re), $signed(im));
      end
      read_addr(ADDR_WIDTH'(5), re, im);
      assert_cnt++;
      if (re !== DATA_WIDTH'(3) || im !== DATA_WIDTH'(-20)) begin
         fail_cnt++;
         $display("FAIL sat_plain: got %0d/%0d want 3/-20", $signed(re), $signed(im));
      end
   endtask

   task automatic test_short();
      logic [DATA_WIDTH-1:0] re, im;
      int n;
      pulse_enable();
      for (int k = 0; k < 5; k++) send(DATA_WIDTH'(k + 1), DATA_WIDTH'(10 * k));
      inFinishedFlag = 1'b1;
      @(posedge clock); #1;
      inFinishedFlag = 1'b0;
      assert_cnt++;
      if (shortFlag !== 1'b1 || loadEnable !== 1'b0 || coeffReady !== 1'b0) begin
         fail_cnt++;
         $display("FAIL short_enter: sf=%b le=%b cr=%b want 1 0 0", shortFlag, loadEnable, coeffReady);
      end
      n = 0;
      while (coeffReady !== 1'b1 && n < 10) begin
         @(posedge clock); #1;
         n++;
      end
      assert_cnt++;
      if (n !== 3) begin
         fail_cnt++; $display("FAIL short_fill_cycles: got %0d want 3", n);
      end
      for (int a = 0; a < LENGTH; a++) begin
         read_addr(ADDR_WIDTH'(a), re, im);
         assert_cnt++;
         if (a < 3) begin
            if (re !== '0 || im !== '0) begin
               fail_cnt++;
               $display("FAIL short_zero[%0d]: got %0d/%0d want 0/0", a, $signed(re), $signed(im));
            end
         end else if (re !== DATA_WIDTH'(8 - a) || im !== DATA_WIDTH'(-10 * (7 - a))) begin
            fail_cnt++;
            $display("FAIL short_data[%0d]: got %0d/%0d want %0d/%0d", a,
                     $signed(re), $signed(im), 8 - a, -10 * (7 - a));
         end
      end
   endtask

   task automatic test_reset_reload();
      logic [DATA_WIDTH-1:0] re, im;
      read_addr(ADDR_WIDTH'(3), re, im);
      pulse_enable();
      for (int k = 0; k < 4; k++) send(DATA_WIDTH'(50 + k), DATA_WIDTH'(k));
      #2 resetN = 1'b0;
      #1;
      assert_cnt++;
      if ({rdRe, rdIm} !== 24'h0 ||
          {loadEnable, coeffReady, shortFlag, overflowFlag} !== 4'b0000) begin
         fail_cnt++;
         $display("FAIL async_reset: rd=%h/%h le=%b cr=%b sf=%b of=%b want all 0",
                  rdRe, rdIm, loadEnable, coeffReady, shortFlag, overflowFlag);
      end
      @(posedge clock); #1;
      resetN = 1'b1;
      send(DATA_WIDTH'(7), DATA_WIDTH'(7));
      @(posedge clock); #1;
      assert_cnt++;
      if (loadEnable !== 1'b0 || coeffReady !== 1'b0 || overflowFlag !== 1'b0) begin
         fail_cnt++;
         $display("FAIL idle_needs_edge: le=%b cr=%b of=%b want 0 0 0", loadEnable, coeffReady, overflowFlag);
      end
      pulse_enable();
      for (int k = 0; k < LENGTH; k++) send(DATA_WIDTH'(100 + k), DATA_WIDTH'(-(k + 3)));
      assert_cnt++;
      if (coeffReady !== 1'b1 || shortFlag !== 1'b0 || overflowFlag !== 1'b0) begin
         fail_cnt++;
         $display("FAIL reload_ready: cr=%b sf=%b of=%b want 1 0 0", coeffReady, shortFlag, overflowFlag);
      end
      for (int a = 0; a < LENGTH; a++) begin
         read_addr(ADDR_WIDTH'(a), re, im);
         assert_cnt++;
         if (re !== DATA_WIDTH'(107 - a) || im !== DATA_WIDTH'(10 - a)) begin
            fail_cnt++;
            $display("FAIL reload_read[%0d]: got %0d/%0d want %0d/%0d", a,
                     $signed(re), $signed(im), 107 - a, 10 - a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_overflow();
      test_gapped();
      test_saturation();
      test_short();
      test_reset_reload();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/mf_coeff_loader.md
Name: mf_coeff_loader

Overview:
- Sits directly downstream of read_MIF_file (DATA_TYPE = 1). Captures the streamed complex coefficient set into an internal register bank.
- Converts the stored set into matched-filter form: time-reversed and conjugated, h[n] = conj(c[LENGTH-1-n]).
- Serves the set to the matched filter through a registered random-access read port.
- Raises coeffReady once the whole bank is valid.

Parameters:
- LENGTH, 800, number of complex coefficients stored.
- DATA_WIDTH, 12, signed width of each real/imag component.
- ADDR_WIDTH, 10, address width; LENGTH <= 2^ADDR_WIDTH is required.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- enable  input  1  start request; a load begins on a 0->1 edge (edge-detected internally).
- inRe  input  DATA_WIDTH  real component of the incoming coefficient (signed).
- inIm  input  DATA_WIDTH  imaginary component of the incoming coefficient (signed).
- inValid  input  1  inRe/inIm hold a new coefficient this cycle.
- inFinishedFlag  input  1  upstream end-of-data (dataFinishedFlag of read_MIF_file).
- rdAddr  input  ADDR_WIDTH  read address from the matched filter.
- rdRe  output  DATA_WIDTH  registered real coefficient at rdAddr.
- rdIm  output  DATA_WIDTH  registered imaginary coefficient at rdAddr.
- loadEnable  output  1  drives the upstream reader's enable; high only in LOAD.
- coeffReady  output  1  bank complete and valid.
- shortFlag  output  1  upstream finished before LENGTH samples arrived.
- overflowFlag  output  1  more than LENGTH valid samples were offered.

Behaviour:
- Reset (resetN = 0, asynchronous):
  - state = IDLE; write count = 0.
  - rdRe = rdIm = 0; loadEnable = coeffReady = shortFlag = overflowFlag = 0.
  - Bank contents are don't-care until the next load completes.
- FSM states: IDLE, LOAD, ZERO_FILL, READY.
- IDLE:
  - enable rising edge -> LOAD; count = 0; all three flags cleared.
- LOAD:
  - loadEnable = 1.
  - Each cycle with inValid = 1 and count < LENGTH writes:
    - bank[LENGTH-1-count].re = inRe
    - bank[LENGTH-1-count].im = -inIm
    - count increments.
  - Negation saturates: -(-2^(DATA_WIDTH-1)) stores 2^(DATA_WIDTH-1)-1 (e.g. -2048 -> 2047 at 12 bits). All other values are exact.
  - When count reaches LENGTH (the cycle after the LENGTH-th write) -> READY.
  - inFinishedFlag = 1 with count < LENGTH (a same-cycle valid sample is written first) -> ZERO_FILL and shortFlag = 1.
- ZERO_FILL:
  - loadEnable = 0.
  - Writes 0+0j to the remaining low addresses, one entry per cycle, from LENGTH-1-count down to address 0.
  - Then -> READY.
- READY:
  - coeffReady = 1; loadEnable = 0.
  - inValid = 1 sets overflowFlag (sticky until the next load); the bank is not modified.
  - An enable rising edge -> LOAD: coeffReady drops to 0 on the same edge and a fresh load starts.
- An enable edge during LOAD or ZERO_FILL is ignored.
- Dropping enable mid-LOAD does not abort the load; only reset aborts.
- Read port:
  - Latency 1: rdRe/rdIm on cycle t+1 reflect bank[rdAddr] as sampled at cycle t.
  - Reads are permitted in any state. They are meaningful only while coeffReady = 1.
  - rdAddr >= LENGTH returns 0+0j.
  - A same-cycle read and write to one address returns the old data.
- Reset mid-load returns to IDLE at once; a new enable edge is required before loading again.

Test Plan:
- Normal load:
  - Setup: LENGTH = 8; feed c[k] = (k+1) + j(10*k) for k = 0..7, one per cycle.
  - Required: coeffReady rises 1 cycle after the 8th write.
  - Required: reading addr 0 gives 8 - j70; addr 7 gives 1 + j0; each read has 1-cycle latency.
- Saturation:
  - Stimulus: a coefficient with inIm = -2048, inRe = -2048.
  - Required: stored as re = -2048, im = +2047.
- Short input:
  - Stimulus: 5 samples, then inFinishedFlag.
  - Required: shortFlag = 1; addrs 0..2 read 0+0j; addrs 3..7 hold conj(c[4..0]); coeffReady rises after 3 fill cycles.
- Overflow and out-of-range read:
  - Stimulus: a 9th inValid in READY, then a read at rdAddr = 8.
  - Required: overflowFlag = 1 and bank unchanged; the read returns 0+0j.
- Gapped input:
  - Stimulus: inValid toggled 1/0 across the 8 samples.
  - Required: identical bank contents to the normal-load case; loadEnable high throughout LOAD.
- Reset and reload:
  - Stimulus: resetN pulsed low after 4 samples, then an enable edge and 8 fresh samples.
  - Required: all outputs go to 0 asynchronously; the second load completes normally with no flags set.
